// File: rtl/rvjtag_pkg.sv
// Shared types for the RISC-V JTAG DTM: TAP states, DMI op/status codes, DTMCS layout.
// Pure declarations; no timing or flow control of its own.
package rvjtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR,      TAP_RTI,
    TAP_SEL_DR,   TAP_CAP_DR,   TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
    TAP_SEL_IR,   TAP_CAP_IR,   TAP_SHIFT_IR, TAP_EXIT1_IR,
    TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  localparam logic [1:0] DMI_STAT_OK     = 2'd0;
  localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
  localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

  localparam int DTMCS_VERSION_LSB   = 0;
  localparam int DTMCS_ABITS_LSB     = 4;
  localparam int DTMCS_DMISTAT_LSB   = 10;
  localparam int DTMCS_IDLE_LSB      = 12;
  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;

  function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                             input logic [1:0] stat,
                                             input logic [5:0] abits);
    logic [31:0] w;
    w = '0;
    w[DTMCS_VERSION_LSB +: 4] = 4'd1;
    w[DTMCS_ABITS_LSB   +: 6] = abits;
    w[DTMCS_DMISTAT_LSB +: 2] = stat;
    w[DTMCS_IDLE_LSB    +: 3] = idle;
    return w;
  endfunction

endpackage

// File: rtl/rvjtag_dtm_tap_if.sv
// DMI request/response bundle between the DTM (master) and the Debug Module (slave).
// Requests are single-cycle pulses; the DM answers with a single-cycle response strobe.
interface rvjtag_dtm_tap_if #(
  parameter int unsigned ABITS = 7
);
  logic             dmi_req_valid;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic             dmi_req_write;
  logic             dmi_rsp_valid;
  logic [31:0]      dmi_rsp_data;
  logic [1:0]       dmi_rsp_status;
  logic             dmi_hard_reset;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write, dmi_hard_reset,
    input  dmi_rsp_valid, dmi_rsp_data, dmi_rsp_status
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write, dmi_hard_reset,
    output dmi_rsp_valid, dmi_rsp_data, dmi_rsp_status
  );
endinterface

// File: rtl/rvjtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state moves on posedge tck, decodes are combinational from state.
// No backpressure; trst low forces Test-Logic-Reset asynchronously.
module rvjtag_tap_fsm
  import rvjtag_pkg::*;
(
  input  logic tck,
  input  logic trst,
  input  logic tms,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= TAP_TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    test_logic_reset_o = 1'b0;
    capture_dr_o       = 1'b0;
    shift_dr_o         = 1'b0;
    update_dr_o        = 1'b0;
    capture_ir_o       = 1'b0;
    shift_ir_o         = 1'b0;
    update_ir_o        = 1'b0;
    case (state_q)
      TAP_TLR:      begin state_d = tms ? TAP_TLR      : TAP_RTI;      test_logic_reset_o = 1'b1; end
      TAP_RTI:            state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:         state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   begin state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR; capture_dr_o = 1'b1; end
      TAP_SHIFT_DR: begin state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR; shift_dr_o   = 1'b1; end
      TAP_EXIT1_DR:       state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR:       state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR:       state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   begin state_d = tms ? TAP_SEL_DR   : TAP_RTI;      update_dr_o  = 1'b1; end
      TAP_SEL_IR:         state_d = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   begin state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR; capture_ir_o = 1'b1; end
      TAP_SHIFT_IR: begin state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR; shift_ir_o   = 1'b1; end
      TAP_EXIT1_IR:       state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR:       state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR:       state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   begin state_d = tms ? TAP_SEL_DR   : TAP_RTI;      update_ir_o  = 1'b1; end
      default:            state_d = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/rvjtag_dtm_tap.sv
// RISC-V JTAG DTM: IR/DR scan chain plus DMI request issue and busy/sticky-error tracking.
// Requests pulse one tck after leaving Update-DR; a request while busy is dropped and flagged sticky.
module rvjtag_dtm_tap
  import rvjtag_pkg::*;
#(
  parameter int unsigned       IR_LEN        = 5,
  parameter int unsigned       ABITS         = 7,
  parameter logic [31:0]       DEVICE_ID_VAL = 32'h0000_0001,
  parameter logic [2:0]        IDLE_HINT     = 3'd1,
  parameter logic [IR_LEN-1:0] IR_IDCODE     = IR_LEN'('h01),
  parameter logic [IR_LEN-1:0] IR_DTMCS      = IR_LEN'('h10),
  parameter logic [IR_LEN-1:0] IR_DMI        = IR_LEN'('h11)
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             scan_mode,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  rvjtag_dtm_tap_if.master dmi
);

  localparam int unsigned DMI_W = ABITS + 34;
  localparam int unsigned SR_W  = (IR_LEN > DMI_W) ? IR_LEN : DMI_W;

  logic tlr, cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir;

  rvjtag_tap_fsm u_fsm (
    .tck                (tck),
    .trst               (trst),
    .tms                (tms),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (cap_dr),
    .shift_dr_o         (shift_dr),
    .update_dr_o        (upd_dr),
    .capture_ir_o       (cap_ir),
    .shift_ir_o         (shift_ir),
    .update_ir_o        (upd_ir)
  );

  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  logic [IR_LEN-1:0] ir_q, ir_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              tdo_q;
  logic              busy_q, busy_d, busy_e;
  logic [1:0]        sticky_q, sticky_d, sticky_e, op_status;
  logic [31:0]       rsp_data_q, rsp_data_d, rsp_data_e;
  logic              req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic [ABITS-1:0]  req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic              hard_reset_q, hard_reset_d;
  logic              sel_idcode, sel_dtmcs, sel_dmi;
  dmi_op_e           upd_op;
  int                msb;

  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_dtmcs  = (ir_q == IR_DTMCS);
  assign sel_dmi    = (ir_q == IR_DMI);
  assign upd_op     = dmi_op_e'(sr_q[1:0]);

  always_comb begin
    ir_d = ir_q;
    if (tlr)         ir_d = IR_IDCODE;
    else if (cap_ir) ir_d = IR_LEN'(1);
    else if (upd_ir) ir_d = (sr_q[IR_LEN-1:0] == '0) ? '1 : sr_q[IR_LEN-1:0];
  end

  // A response landing in the same cycle as a capture or update is applied first.
  always_comb begin
    busy_e     = busy_q;
    sticky_e   = sticky_q;
    rsp_data_e = rsp_data_q;
    if (dmi.dmi_rsp_valid && busy_q) begin
      busy_e     = 1'b0;
      rsp_data_e = dmi.dmi_rsp_data;
      if (dmi.dmi_rsp_status != DMI_STAT_OK) sticky_e = DMI_STAT_FAILED;
    end
    if (sticky_e != DMI_STAT_OK) op_status = sticky_e;
    else if (busy_e)             op_status = DMI_STAT_BUSY;
    else                         op_status = DMI_STAT_OK;
  end

  always_comb begin
    sr_d = sr_q;
    msb  = 0;
    if (shift_ir)                     msb = int'(IR_LEN) - 1;
    else if (sel_dmi)                 msb = int'(DMI_W) - 1;
    else if (sel_idcode || sel_dtmcs) msb = 31;
    if (cap_ir) begin
      sr_d      = '0;
      sr_d[1:0] = 2'b01;
    end else if (cap_dr) begin
      sr_d = '0;
      if (sel_dmi)         sr_d[DMI_W-1:0] = {req_addr_q, rsp_data_e, op_status};
      else if (sel_dtmcs)  sr_d[31:0] = dtmcs_word(IDLE_HINT, sticky_e, 6'(ABITS));
      else if (sel_idcode) sr_d[31:0] = DEVICE_ID_VAL;
    end else if (shift_dr || shift_ir) begin
      sr_d = sr_q >> 1;
      for (int i = 0; i < int'(SR_W); i++) begin
        if (i == msb) sr_d[i] = tdi;
      end
    end
  end

  always_comb begin
    busy_d       = busy_e;
    sticky_d     = sticky_e;
    rsp_data_d   = rsp_data_e;
    req_valid_d  = 1'b0;
    hard_reset_d = 1'b0;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_write_d  = req_write_q;
    if (upd_dr && sel_dtmcs) begin
      if (sr_q[DTMCS_DMIRESET_BIT]) sticky_d = DMI_STAT_OK;
      if (sr_q[DTMCS_HARDRESET_BIT]) begin
        sticky_d     = DMI_STAT_OK;
        busy_d       = 1'b0;
        hard_reset_d = 1'b1;
      end
    end
    // Any sticky error silently drops new requests until a dmireset.
    if (upd_dr && sel_dmi && (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)
        && sticky_e == DMI_STAT_OK) begin
      if (busy_e) begin
        sticky_d = DMI_STAT_BUSY;
      end else begin
        req_valid_d = 1'b1;
        busy_d      = 1'b1;
        req_addr_d  = sr_q[DMI_W-1:34];
        req_data_d  = sr_q[33:2];
        req_write_d = (upd_op == DMI_OP_WRITE);
      end
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      sr_q         <= '0;
      busy_q       <= 1'b0;
      sticky_q     <= DMI_STAT_OK;
      rsp_data_q   <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_write_q  <= 1'b0;
      hard_reset_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      busy_q       <= busy_d;
      sticky_q     <= sticky_d;
      rsp_data_q   <= rsp_data_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_write_q  <= req_write_d;
      hard_reset_q <= hard_reset_d;
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir_q  <= IR_IDCODE;
      tdo_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      tdo_q <= sr_q[0];
    end
  end

  assign tdo                = tdo_q;
  assign tdo_en             = shift_dr | shift_ir;
  assign dmi.dmi_req_valid  = req_valid_q;
  assign dmi.dmi_req_addr   = req_addr_q;
  assign dmi.dmi_req_data   = req_data_q;
  assign dmi.dmi_req_write  = req_write_q;
  assign dmi.dmi_hard_reset = hard_reset_q;

endmodule

// File: doc/rvjtag_dtm_tap.md
# rvjtag_dtm_tap

JTAG Debug Transport Module TAP for the RISC-V debug path: the parametrised successor of the fixed-width DMI TAP. It implements the IEEE 1149.1 TAP controller and the IDCODE, DTMCS, DMI and BYPASS data registers. DMI address width and IR length are parametrised, and it adds a req/rsp handshake toward the Debug Module with busy tracking and a sticky DMI error status. It sits between the JTAG pads and the DMI synchroniser/Debug Module; all logic runs in the tck domain.

## Interface
- IR_LEN, 5: instruction register width; must be ≥ 5.
- ABITS, 7: DMI address width, 1..32.
- DEVICE_ID_VAL, 32'h0000_0001: IDCODE value; bit 0 must be 1.
- IDLE_HINT, 3'd1: DTMCS.idle field.
- IR_IDCODE, 'h01: IDCODE opcode.
- IR_DTMCS, 'h10: DTMCS opcode.
- IR_DMI, 'h11: DMI opcode.
- tck  in  1  JTAG clock.
- trst  in  1  reset; asynchronous, active-low.
- scan_mode  in  1  DFT mode; the block makes no functional use of it.
- tms, tdi  in  1  JTAG mode select and data in.
- tdo  out  1  JTAG data out, updated on the negedge of tck.
- tdo_en  out  1  pad output enable.
- dmi_req_valid  out  1  one-tck request pulse to the DM.
- dmi_req_addr  out  ABITS  request address.
- dmi_req_data  out  32  request write data.
- dmi_req_write  out  1  1 = write, 0 = read.
- dmi_rsp_valid  in  1  one-tck response strobe from the DM.
- dmi_rsp_data  in  32  read data; sampled when dmi_rsp_valid is high.
- dmi_rsp_status  in  2  0 = ok, 2 = failed; any other value is treated as 2.
- dmi_hard_reset  out  1  one-tck pulse on a DTMCS.dmihardreset write.

## Operation
- TAP FSM: the 16 standard states, with standard tms transitions; state changes on the posedge of tck. trst low forces Test-Logic-Reset. Five tck cycles with tms=1 reach Test-Logic-Reset from any state.
- IR is written on the negedge of tck.
  - Reset and Test-Logic-Reset load IR_IDCODE.
  - Update-IR loads the shifted value; an all-zero value loads all-ones (BYPASS).
  - Capture-IR loads {0…,2'b01}.
- DR select: IR_IDCODE → 32-bit; IR_DTMCS → 32-bit; IR_DMI → ABITS+34-bit {addr, data, op}; any other opcode → 1-bit BYPASS.
- Shift-DR/IR: shift right, tdi enters at the MSB of the selected register length, and bit 0 drives tdo. tdo_en = Shift-DR | Shift-IR.
- DTMCS capture value: {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat, ABITS[5:0], 4'd1}, where dmistat = sticky.
- DTMCS update:
  - bit16 (dmireset) clears sticky.
  - bit17 (dmihardreset) clears sticky and busy, drops any outstanding request, and pulses dmi_hard_reset.
- DMI capture value: {last_addr, rsp_data_reg, op_status}. op_status = sticky if sticky≠0, else 3 if busy, else 0.
- DMI update, by op field:
  - op 0 and op 3: no action.
  - op 1 (read) or op 2 (write), with sticky≠0: request dropped.
  - op 1 or op 2, with busy=1 and sticky=0: request dropped and sticky←3.
  - op 1 or op 2, otherwise: last_addr/req fields latched, dmi_req_valid pulsed, busy←1.
- Response handling: dmi_rsp_valid while busy sets busy←0 and loads rsp_data_reg. If the status is nonzero, sticky←2. dmi_rsp_valid while not busy is ignored.
- Simultaneous dmi_rsp_valid and a DMI Update-DR in the same tck: the response is applied first, so the update sees busy=0.
- Reset values: every register is 0 except IR; outputs are tdo=0, tdo_en=0, all dmi_req_* = 0, dmi_hard_reset=0.

## Timing
- The dmi_req_* outputs are registered. dmi_req_valid is high for exactly the tck cycle following the posedge that leaves Update-DR. addr, data and write stay stable until the next request.
- dmi_hard_reset: a one-cycle pulse, with the same timing as dmi_req_valid.
- tdo: follows sr[0], registered on the negedge of tck; data is valid half a cycle after the shift edge.
- Round trip: a DMI result is visible in the next Capture-DR only if dmi_rsp_valid arrived at or before the Capture-DR posedge.
- trst assertion mid-transaction clears busy/sticky immediately. Any response arriving after reset is ignored.

## Structure
- Package rvjtag_pkg holds:
  - the tap_state_e enum (16 states);
  - the DMI op encodings (NOP, READ, WRITE, RSVD);
  - the status codes (OK=0, FAILED=2, BUSY=3);
  - the DTMCS field bit positions.
- Sub-module rvjtag_tap_fsm: the TAP state register and next-state logic, producing one-hot decodes (capture/shift/update for DR and IR, and test_logic_reset).
- Top level: IR, shift register, DTMCS/DMI logic, and the busy/sticky tracker.

## Test plan
- Reset/ID: trst low, then release; 32 DR shifts → tdo stream equals DEVICE_ID_VAL, LSB first (0x00000001).
- BYPASS: IR=0x1F; shift 8 bits 0xA5 → tdo shows the same bits delayed by exactly one tck; an IR scan of 0x00 behaves identically.
- DMI write then read:
  - write {addr=0x10, data=0xDEADBEEF, op=2} → one dmi_req_valid pulse with write=1 and the matching fields.
  - DM answers with status 0, then a read is issued and answered with 0x12345678 → the next capture returns data=0x12345678 and op=0.
- Busy overrun: issue a read and withhold dmi_rsp_valid; a second DMI update → no new request, and capture shows op=3. DTMCS capture shows dmistat=3. A DTMCS write with bit16=1 → dmistat=0.
- Failed response: rsp_status=2 → capture op=2. Later requests are dropped until a dmireset write.
- Hard reset: DTMCS write with bit17=1 while busy → one-cycle dmi_hard_reset pulse, busy=0, and a new DMI read issues immediately.
